// File: rtl/receive_module.sv
// receive_module: UART receiver, 8 data bits LSB first, even parity, one stop bit,
// sampled on an oversampled baud tick.
module receive_module #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Rx_EN,
  input  logic       RxD,
  input  logic       baud_tick,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR,
  output logic       Rx_BUSY
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tick, tick_nx;
  logic [2:0] bit_idx, bit_nx;
  logic [7:0] shift, shift_nx, data_nx;
  logic par_err, par_nx, valid_nx, perr_nx, ferr_nx;
  logic sync1, rxd_s;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
      state <= IDLE;
      tick <= '0;
      bit_idx <= '0;
      shift <= '0;
      par_err <= 1'b0;
      Rx_DATA <= '0;
      Rx_VALID <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      sync1 <= RxD;
      rxd_s <= sync1;
      state <= state_nx;
      tick <= tick_nx;
      bit_idx <= bit_nx;
      shift <= shift_nx;
      par_err <= par_nx;
      Rx_DATA <= data_nx;
      Rx_VALID <= valid_nx;
      Rx_PERROR <= perr_nx;
      Rx_FERROR <= ferr_nx;
    end
  end
  always_comb begin
    state_nx = state;
    tick_nx = tick;
    bit_nx = bit_idx;
    shift_nx = shift;
    par_nx = par_err;
    data_nx = Rx_DATA;
    perr_nx = Rx_PERROR;
    ferr_nx = Rx_FERROR;
    valid_nx = 1'b0;
    if (!Rx_EN) begin
      state_nx = IDLE;
      tick_nx = '0;
      bit_nx = '0;
    end else if (baud_tick) begin
      tick_nx = tick + 1'b1;
      case (state)
        IDLE: begin
          tick_nx = '0;
          state_nx = rxd_s ? IDLE : START;
        end
        START: if (tick == HALF) begin
          // mid start bit: a high line here was only a glitch
          tick_nx = '0;
          bit_nx = '0;
          state_nx = rxd_s ? IDLE : DATA;
          perr_nx = rxd_s ? Rx_PERROR : 1'b0;
          ferr_nx = rxd_s ? Rx_FERROR : 1'b0;
        end
        DATA: if (tick == FULL) begin
          tick_nx = '0;
          shift_nx = {rxd_s, shift[7:1]};
          bit_nx = bit_idx + 3'd1;
          state_nx = (bit_idx == 3'd7) ? PARITY : DATA;
        end
        PARITY: if (tick == FULL) begin
          tick_nx = '0;
          par_nx = rxd_s != ^shift;
          state_nx = STOP;
        end
        STOP: if (tick == FULL) begin
          // leaving mid stop bit lets a back-to-back start edge be caught
          tick_nx = '0;
          data_nx = shift;
          perr_nx = par_err;
          ferr_nx = !rxd_s;
          valid_nx = !par_err && rxd_s;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  assign Rx_BUSY = state != IDLE;
endmodule
